// File: rtl/mdu_core.sv
// EX-stage multiply/divide unit: computes MULT/MULTU/DIV/DIVU results at accept,
// holds them pending for a fixed busy latency, then commits them to architectural HI/LO.
module mdu_core #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 4;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    pend_hi;
    logic [W-1:0]    pend_lo;
    logic            pend_wr;

    logic            op_mul;
    logic            op_div;
    logic            accept_run;
    logic            wr_mthi;
    logic            wr_mtlo;
    logic            commit;

    logic [2*W-1:0]  prod;
    logic [W-1:0]    divisor;
    logic [W-1:0]    quo;
    logic [W-1:0]    rem;

    assign op_mul = (op == OP_MULT) || (op == OP_MULTU);
    assign op_div = (op == OP_DIV)  || (op == OP_DIVU);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start && (op_mul || op_div)) state_next = RUN;
            RUN:  if (cnt <= CW'(1))               state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control strobes; anything arriving while RUN is dropped
    always_comb begin
        accept_run = 1'b0;
        wr_mthi    = 1'b0;
        wr_mtlo    = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                accept_run = start && (op_mul || op_div);
                wr_mthi    = start && (op == OP_MTHI);
                wr_mtlo    = start && (op == OP_MTLO);
            end
            RUN: commit = (cnt <= CW'(1)) && pend_wr;
            default: ;
        endcase
    end

    // Arithmetic; divisor forced nonzero so a divide by zero yields defined (discarded) values
    always_comb begin
        prod    = '0;
        quo     = '0;
        rem     = '0;
        divisor = (b == '0) ? W'(1) : b;
        if (op == OP_MULT)
            prod = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
        else
            prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        if (op == OP_DIV) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                quo = a;
                rem = '0;
            end else begin
                quo = W'($signed(a) / $signed(divisor));
                rem = W'($signed(a) % $signed(divisor));
            end
        end else begin
            quo = a / divisor;
            rem = a % divisor;
        end
    end

    assign busy = (state == RUN);

    // Counter, pending result and architectural HI/LO
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            if (accept_run) begin
                if (op_mul) begin
                    cnt     <= CW'(MULT_CYCLES);
                    pend_hi <= prod[2*W-1:W];
                    pend_lo <= prod[W-1:0];
                    pend_wr <= 1'b1;
                end else begin
                    cnt     <= CW'(DIV_CYCLES);
                    pend_hi <= rem;
                    pend_lo <= quo;
                    pend_wr <= (b != '0);
                end
            end else if (state == RUN) begin
                cnt <= cnt - CW'(1);
            end

            if (commit) begin
                hi <= pend_hi;
                lo <= pend_lo;
            end
            if (wr_mthi) hi <= a;
            if (wr_mtlo) lo <= a;
        end
    end

endmodule

// File: tb/tb_mdu_core.sv
// Self-checking bench for mdu_core: vector table plus hand-written busy-period corner cases.
module tb_mdu_core;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    mdu_core #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        wr_hi;
        logic        wr_lo;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] ref_hi;
    logic [31:0] ref_lo;
    res_t        exp_q[$];
    vec_t        tbl[12];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    // inj_kind: 0 none, 1 MTLO strobe during busy, 2 reset pulse during busy
    task automatic run_vec(input vec_t v, input int inj_cycle, input int inj_kind);
        res_t e;
        int   cycles;
        logic hold_ok;
        @(negedge clk);
        start = 1'b1; op = v.op; a = v.a; b = v.b;
        e.hi = v.wr_hi ? v.hi : ref_hi;
        e.lo = v.wr_lo ? v.lo : ref_lo;
        exp_q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        cycles  = 0;
        hold_ok = 1'b1;
        while (busy && cycles < 40) begin
            if (hi !== ref_hi || lo !== ref_lo) hold_ok = 1'b0;
            cycles++;
            if (cycles == inj_cycle) begin
                @(negedge clk);
                if (inj_kind == 1) begin
                    start = 1'b1; op = 3'd5; a = 32'hDEADBEEF;
                end else begin
                    reset = 1'b1;
                end
            end
            @(posedge clk); #1;
            start = 1'b0;
            reset = 1'b0;
        end
        e = exp_q.pop_front();
        check("hold_while_busy", 32'(hold_ok), 32'd1);
        if (inj_kind == 2) begin
            ref_hi = '0;
            ref_lo = '0;
            check("reset_cut_busy_len", 32'(cycles), 32'(inj_cycle));
            check("reset_hi", hi, 32'h0);
            check("reset_lo", lo, 32'h0);
            repeat (12) @(posedge clk);
            #1;
            check("no_late_busy", 32'(busy), 32'd0);
            check("no_late_hi", hi, 32'h0);
            check("no_late_lo", lo, 32'h0);
        end else begin
            check("busy_cycles", 32'(cycles), 32'(v.cyc));
            check("hi", hi, e.hi);
            check("lo", lo, e.lo);
            ref_hi = e.hi;
            ref_lo = e.lo;
        end
    endtask

    task automatic reserved_op(input logic [2:0] o);
        @(negedge clk);
        start = 1'b1; op = o; a = 32'hA5A5A5A5; b = 32'h3;
        @(posedge clk); #1;
        start = 1'b0;
        check("rsv_busy", 32'(busy), 32'd0);
        check("rsv_hi", hi, ref_hi);
        check("rsv_lo", lo, ref_lo);
        @(posedge clk); #1;
        check("rsv_busy_later", 32'(busy), 32'd0);
    endtask

    initial begin
        tbl[0]  = '{3'd1, 32'hFFFFFFFF, 32'd2,        1'b1, 1'b1, 32'h00000001, 32'hFFFFFFFE, 5};
        tbl[1]  = '{3'd0, 32'hFFFFFFFD, 32'd5,        1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1, 5};
        tbl[2]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        tbl[3]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h00000000, 32'h80000000, 10};
        tbl[4]  = '{3'd0, 32'h80000000, 32'h80000000, 1'b1, 1'b1, 32'h40000000, 32'h00000000, 5};
        tbl[5]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 32'hFFFFFFFE, 32'h00000001, 5};
        tbl[6]  = '{3'd2, 32'd7,        32'hFFFFFFFE, 1'b1, 1'b1, 32'h00000001, 32'hFFFFFFFD, 10};
        tbl[7]  = '{3'd3, 32'hFFFFFFFF, 32'd10,       1'b1, 1'b1, 32'h00000005, 32'h19999999, 10};
        tbl[8]  = '{3'd4, 32'h12345678, 32'd0,        1'b1, 1'b0, 32'h12345678, 32'h0,        0};
        tbl[9]  = '{3'd5, 32'h9ABCDEF0, 32'd0,        1'b0, 1'b1, 32'h0,        32'h9ABCDEF0, 0};
        tbl[10] = '{3'd3, 32'd100,      32'd0,        1'b0, 1'b0, 32'h0,        32'h0,        10};
        tbl[11] = '{3'd3, 32'd17,       32'd5,        1'b1, 1'b1, 32'h00000002, 32'h00000003, 10};

        // Reset, with a start asserted that reset must override
        reset = 1'b1; start = 1'b1; op = 3'd4; a = 32'hFFFFFFFF; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        ref_hi = '0;
        ref_lo = '0;

        for (int i = 0; i < 12; i++) run_vec(tbl[i], 0, 0);

        // DIV 100/7 with an MTLO strobe on busy cycle 3, then DIVU 17/5 right after busy falls
        run_vec('{3'd2, 32'd100, 32'd7, 1'b1, 1'b1, 32'd2, 32'd14, 10}, 3, 1);
        run_vec(tbl[11], 0, 0);

        // DIV interrupted by reset on busy cycle 4
        run_vec(tbl[2], 4, 2);

        reserved_op(3'd6);
        run_vec(tbl[8], 0, 0);
        reserved_op(3'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
